text_grid_scheduler: RTL and testbench

- Sole owner of the text-grid buffer write port (tg_we/tg_addr/tg_input).
- Shares the port between three requesters:
  - keyboard path: single-cycle write pulses from the terminal controller, which cannot stall;
  - program-output character stream: valid/ready, with an internal output cursor;
  - clear sequencer: sweeps every cell to space.
- Sits between the terminal controller / interpreter output and the text-grid BRAM.

---
 rtl/text_grid_scheduler.sv | 170 +++++++++++++++++
 tb/tb_text_grid_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_grid_scheduler.sv
// Sole owner of the text-grid write port: arbitrates keyboard writes, the program-output stream and a clear sweep.
// Optional: define TG_WRAP_CLEAR_EN so that an output-cursor wrap past the last row triggers a full clear.
module text_grid_scheduler #(
  parameter int SCREEN_WIDTH  = 76,
  parameter int SCREEN_HEIGHT = 44,
  parameter int ADDR_W        = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic                             pixel_clk_in,
  input  logic                             rst_n_in,
  input  logic                             kb_we_in,
  input  logic [ADDR_W-1:0]                kb_addr_in,
  input  logic [7:0]                       kb_data_in,
  output logic                             kb_drop_out,
  input  logic                             out_valid_in,
  input  logic [7:0]                       out_char_in,
  output logic                             out_ready_out,
  input  logic                             clr_req_in,
  output logic                             clr_busy_out,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  out_cursor_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] out_cursor_y,
  output logic                             tg_we,
  output logic [ADDR_W-1:0]                tg_addr,
  output logic [7:0]                       tg_input
);

  localparam int CX_W  = $clog2(SCREEN_WIDTH);
  localparam int CY_W  = $clog2(SCREEN_HEIGHT);
  localparam int CELLS = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam logic [ADDR_W:0]   CELLS_EXT = (ADDR_W+1)'(CELLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [CX_W-1:0]   X_MAX     = CX_W'(SCREEN_WIDTH - 1);
  localparam logic [CY_W-1:0]   Y_MAX     = CY_W'(SCREEN_HEIGHT - 1);
  localparam logic [7:0]        CH_BS     = 8'd8;
  localparam logic [7:0]        CH_NL     = 8'd10;
  localparam logic [7:0]        CH_SP     = 8'd32;

`ifdef TG_WRAP_CLEAR_EN
  localparam bit WRAP_CLEAR = 1'b1;
`else
  localparam bit WRAP_CLEAR = 1'b0;
`endif

  // RUN: serve keyboard and output stream; CLEAR: sweep spaces over every cell
  typedef enum logic {ST_RUN, ST_CLEAR} state_t;

  state_t            r_state;
  logic [CX_W-1:0]   r_cx;
  logic [CY_W-1:0]   r_cy;
  logic [ADDR_W-1:0] r_sweep;
  logic              r_tg_we;
  logic [ADDR_W-1:0] r_tg_addr;
  logic [7:0]        r_tg_input;
  logic              r_kb_drop;
  logic              r_busy;
  logic              r_wrap_pend;

  logic              w_clr_req;
  logic              w_xfer;
  logic              w_is_bs;
  logic              w_is_nl;
  logic              w_at_xmax;
  logic              w_at_ymax;
  logic              w_at_origin;
  logic              w_wrap;
  logic [ADDR_W-1:0] w_cur_addr;

  // A pending wrap behaves exactly like an external clear request
  assign w_clr_req     = clr_req_in | r_wrap_pend;
  assign out_ready_out = (r_state == ST_RUN) && !kb_we_in && !w_clr_req;
  assign w_xfer        = out_valid_in && out_ready_out;
  assign w_is_bs       = (out_char_in == CH_BS);
  assign w_is_nl       = (out_char_in == CH_NL);
  assign w_at_xmax     = (r_cx == X_MAX);
  assign w_at_ymax     = (r_cy == Y_MAX);
  assign w_at_origin   = (r_cx == '0) && (r_cy == '0);
  assign w_cur_addr    = ADDR_W'(r_cy) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(r_cx);
  assign w_wrap        = w_xfer && !w_is_bs && w_at_ymax && (w_is_nl || w_at_xmax);

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= ST_RUN;
      r_cx        <= '0;
      r_cy        <= '0;
      r_sweep     <= '0;
      r_tg_we     <= 1'b0;
      r_tg_addr   <= '0;
      r_tg_input  <= '0;
      r_kb_drop   <= 1'b0;
      r_busy      <= 1'b0;
      r_wrap_pend <= 1'b0;
    end else begin
      r_tg_we     <= 1'b0;
      r_kb_drop   <= 1'b0;
      r_wrap_pend <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_busy <= 1'b0;
          if (w_clr_req) begin
            // First sweep write is issued from the accepting cycle
            r_state    <= ST_CLEAR;
            r_tg_we    <= 1'b1;
            r_tg_addr  <= '0;
            r_tg_input <= CH_SP;
            r_sweep    <= ADDR_W'(1);
            r_busy     <= 1'b1;
            r_kb_drop  <= kb_we_in;
          end else if (kb_we_in) begin
            if ({1'b0, kb_addr_in} < CELLS_EXT) begin
              r_tg_we    <= 1'b1;
              r_tg_addr  <= kb_addr_in;
              r_tg_input <= kb_data_in;
            end else begin
              r_kb_drop <= 1'b1;
            end
          end else if (w_xfer) begin
            if (w_is_bs) begin
              // Stepping back one cell is always linear address - 1
              if (!w_at_origin) begin
                r_tg_we    <= 1'b1;
                r_tg_addr  <= w_cur_addr - ADDR_W'(1);
                r_tg_input <= CH_SP;
                if (r_cx != '0) begin
                  r_cx <= r_cx - CX_W'(1);
                end else begin
                  r_cx <= X_MAX;
                  r_cy <= r_cy - CY_W'(1);
                end
              end
            end else begin
              r_tg_we    <= 1'b1;
              r_tg_addr  <= w_cur_addr;
              r_tg_input <= out_char_in;
              if (w_is_nl || w_at_xmax) begin
                r_cx <= '0;
                r_cy <= w_at_ymax ? '0 : r_cy + CY_W'(1);
              end else begin
                r_cx <= r_cx + CX_W'(1);
              end
              r_wrap_pend <= WRAP_CLEAR && w_wrap;
            end
          end
        end
        ST_CLEAR: begin
          r_tg_we    <= 1'b1;
          r_tg_addr  <= r_sweep;
          r_tg_input <= CH_SP;
          r_busy     <= 1'b1;
          r_kb_drop  <= kb_we_in;
          r_sweep    <= r_sweep + ADDR_W'(1);
          if (r_sweep == LAST_ADDR) begin
            r_state <= ST_RUN;
            r_sweep <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign tg_we        = r_tg_we;
  assign tg_addr      = r_tg_addr;
  assign tg_input     = r_tg_input;
  assign kb_drop_out  = r_kb_drop;
  assign clr_busy_out = r_busy;
  assign out_cursor_x = r_cx;
  assign out_cursor_y = r_cy;

endmodule

// File: tb/tb_text_grid_scheduler.sv
// Bench for text_grid_scheduler: a 76x44 instance and a 4x2 instance checked against a linear-address model.
module tb_text_grid_scheduler;
  localparam int BW = 76, BH = 44, SW = 4, SH = 2;
`ifdef TG_WRAP_CLEAR_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef struct { int addr; int data; int cyc; } wr_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        b_kb_we = 0, b_valid = 0, b_clr = 0;
  logic [11:0] b_kb_addr = '0;
  logic [7:0]  b_kb_data = '0, b_char = '0;
  logic        b_drop, b_ready, b_busy, b_we;
  logic [6:0]  b_cx;
  logic [5:0]  b_cy;
  logic [11:0] b_addr;
  logic [7:0]  b_data;

  logic        s_kb_we = 0, s_valid = 0, s_clr = 0;
  logic [2:0]  s_kb_addr = '0;
  logic [7:0]  s_kb_data = '0, s_char = '0;
  logic        s_drop, s_ready, s_busy, s_we;
  logic [1:0]  s_cx;
  logic [0:0]  s_cy;
  logic [2:0]  s_addr;
  logic [7:0]  s_data;

  text_grid_scheduler #(.SCREEN_WIDTH(BW), .SCREEN_HEIGHT(BH), .ADDR_W(12)) u_big (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .kb_we_in(b_kb_we), .kb_addr_in(b_kb_addr),
    .kb_data_in(b_kb_data), .kb_drop_out(b_drop), .out_valid_in(b_valid), .out_char_in(b_char),
    .out_ready_out(b_ready), .clr_req_in(b_clr), .clr_busy_out(b_busy), .out_cursor_x(b_cx),
    .out_cursor_y(b_cy), .tg_we(b_we), .tg_addr(b_addr), .tg_input(b_data));

  text_grid_scheduler #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .ADDR_W(3)) u_small (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .kb_we_in(s_kb_we), .kb_addr_in(s_kb_addr),
    .kb_data_in(s_kb_data), .kb_drop_out(s_drop), .out_valid_in(s_valid), .out_char_in(s_char),
    .out_ready_out(s_ready), .clr_req_in(s_clr), .clr_busy_out(s_busy), .out_cursor_x(s_cx),
    .out_cursor_y(s_cy), .tg_we(s_we), .tg_addr(s_addr), .tg_input(s_data));

  int n_cmp = 0, n_err = 0, cyc = 0;
  wr_t b_obs[$], s_obs[$], b_exp[$], s_exp[$];
  int b_drops = 0, s_drops = 0, s_busy_cnt = 0;
  int b_mx = 0, b_my = 0, s_mx = 0, s_my = 0;
  wr_t mw;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b_we === 1'b1) begin
      mw.addr = int'(b_addr); mw.data = int'(b_data); mw.cyc = cyc; b_obs.push_back(mw);
    end
    if (s_we === 1'b1) begin
      mw.addr = int'(s_addr); mw.data = int'(s_data); mw.cyc = cyc; s_obs.push_back(mw);
    end
    if (b_drop === 1'b1) b_drops++;
    if (s_drop === 1'b1) s_drops++;
    if (s_busy === 1'b1) s_busy_cnt++;
  end

  task automatic exp_push(input bit sm, input int a, input int d);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = 0;
    if (sm) s_exp.push_back(w); else b_exp.push_back(w);
  endtask

  // Reference: cursor as a linear cell index, with row wrap and optional clear
  task automatic model_char(input bit sm, input int c);
    int w, h, cx, cy, a;
    bit wrapped;
    w = sm ? SW : BW; h = sm ? SH : BH;
    cx = sm ? s_mx : b_mx; cy = sm ? s_my : b_my;
    a = cy * w + cx;
    wrapped = 1'b0;
    if (c == 8) begin
      if (a > 0) begin
        a = a - 1;
        exp_push(sm, a, 32);
        cx = a % w; cy = a / w;
      end
    end else begin
      exp_push(sm, a, c);
      if (c == 10) begin
        cx = 0; cy = cy + 1;
      end else begin
        cx = cx + 1;
        if (cx == w) begin cx = 0; cy = cy + 1; end
      end
      if (cy == h) begin cy = 0; wrapped = 1'b1; end
    end
    if (wrapped && WRAP_EN) for (int i = 0; i < w * h; i++) exp_push(sm, i, 32);
    if (sm) begin s_mx = cx; s_my = cy; end else begin b_mx = cx; b_my = cy; end
  endtask

  task automatic send(input bit sm, input logic [7:0] c);
    int n;
    logic rdy;
    n = 0;
    @(negedge clk);
    if (sm) begin s_valid = 1'b1; s_char = c; end else begin b_valid = 1'b1; b_char = c; end
    #1 rdy = sm ? s_ready : b_ready;
    while (rdy !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1 rdy = sm ? s_ready : b_ready;
      n++;
    end
    if (rdy !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout ready=%0b required=1", rdy);
    end else begin
      model_char(sm, int'(c));
    end
    @(posedge clk);
    #1;
    b_valid = 1'b0; s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    b_obs.delete(); s_obs.delete(); b_exp.delete(); s_exp.delete();
  endtask

  function automatic logic [7:0] rand_char();
    int p;
    p = $urandom_range(0, 9);
    if (p == 0) return 8'd10;
    if (p == 1) return 8'd8;
    return 8'($urandom_range(32, 126));
  endfunction

  task automatic test_reset();
    int snap;
    send(0, 8'h70); send(0, 8'h71); send(1, 8'h72);
    @(negedge clk); s_clr = 1'b1; b_valid = 1'b1; b_char = 8'h73;
    @(negedge clk); s_clr = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (s_busy !== 1'b1) begin n_err++; $display("FAIL pre_reset_busy got=%0b exp=1", s_busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (b_we !== 1'b0 || s_we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%0b/%0b exp=0", b_we, s_we); end
    n_cmp++; if (b_addr !== 12'd0 || b_data !== 8'd0) begin n_err++; $display("FAIL reset_addr_data got=%0d/%0d exp=0", b_addr, b_data); end
    n_cmp++; if (s_busy !== 1'b0 || b_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b/%0b exp=0", s_busy, b_busy); end
    n_cmp++; if (b_drop !== 1'b0) begin n_err++; $display("FAIL reset_drop got=%0b exp=0", b_drop); end
    n_cmp++; if (b_cx !== 7'd0 || b_cy !== 6'd0 || s_cx !== 2'd0 || s_cy !== 1'd0) begin
      n_err++; $display("FAIL reset_cursor got=(%0d,%0d)/(%0d,%0d) exp=(0,0)", b_cx, b_cy, s_cx, s_cy);
    end
    b_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++; if (b_ready !== 1'b1 || s_ready !== 1'b1) begin n_err++; $display("FAIL release_ready got=%0b/%0b exp=1", b_ready, s_ready); end
    snap = s_obs.size();
    idle(12);
    n_cmp++; if (s_obs.size() !== snap) begin n_err++; $display("FAIL sweep_abandoned got=%0d writes exp=0", s_obs.size() - snap); end
    clear_q();
    b_mx = 0; b_my = 0; s_mx = 0; s_my = 0;
  endtask

  task automatic test_keyboard();
    @(negedge clk); b_kb_we = 1'b1; b_kb_addr = 12'd77; b_kb_data = 8'h61;
    @(negedge clk); b_kb_we = 1'b0;
    #1;
    n_cmp++; if (b_we !== 1'b1 || b_addr !== 12'd77 || b_data !== 8'h61) begin
      n_err++; $display("FAIL kb_write got=(%0b,%0d,0x%0h) exp=(1,77,0x61)", b_we, b_addr, b_data);
    end
    n_cmp++; if (b_cx !== 7'd0 || b_cy !== 6'd0) begin n_err++; $display("FAIL kb_cursor got=(%0d,%0d) exp=(0,0)", b_cx, b_cy); end
    @(negedge clk); b_kb_we = 1'b1; b_kb_addr = 12'd3344; b_kb_data = 8'h41;
    @(negedge clk); b_kb_we = 1'b0;
    #1;
    n_cmp++; if (b_we !== 1'b0 || b_drop !== 1'b1) begin n_err++; $display("FAIL kb_oob got we=%0b drop=%0b exp we=0 drop=1", b_we, b_drop); end
    idle(2);
    n_cmp++; if (b_obs.size() !== 1) begin n_err++; $display("FAIL kb_write_count got=%0d exp=1", b_obs.size()); end
    clear_q();
  endtask

  task automatic test_stream();
    send(0, 8'h61); send(0, 8'h62); send(0, 8'd10); send(0, 8'h63);
    idle(3);
    n_cmp++; if (b_cx !== 7'd1 || b_cy !== 6'd1) begin n_err++; $display("FAIL stream_cursor got=(%0d,%0d) exp=(1,1)", b_cx, b_cy); end
    send(0, 8'd8); send(0, 8'd8);
    idle(3);
    n_cmp++; if (b_cx !== 7'd75 || b_cy !== 6'd0) begin n_err++; $display("FAIL bs_cursor got=(%0d,%0d) exp=(75,0)", b_cx, b_cy); end
    n_cmp++;
    if (b_obs.size() !== b_exp.size()) begin
      n_err++; $display("FAIL stream_count got=%0d exp=%0d", b_obs.size(), b_exp.size());
    end else begin
      foreach (b_exp[i]) begin
        n_cmp++;
        if (b_obs[i].addr !== b_exp[i].addr || b_obs[i].data !== b_exp[i].data) begin
          n_err++; $display("FAIL stream_write[%0d] got=(%0d,0x%0h) exp=(%0d,0x%0h)", i, b_obs[i].addr, b_obs[i].data, b_exp[i].addr, b_exp[i].data);
        end
      end
    end
    clear_q();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); b_valid = 1'b1; b_char = 8'h78;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      b_kb_we = 1'b1; b_kb_addr = 12'($urandom_range(0, 3343)); b_kb_data = 8'($urandom_range(32, 126));
      exp_push(0, int'(b_kb_addr), int'(b_kb_data));
      #1;
      n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready[%0d] got=%0b exp=0", i, b_ready); end
    end
    @(negedge clk); b_kb_we = 1'b0;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL b2b_release got=%0b exp=1", b_ready); end
    @(posedge clk);
    #1 b_valid = 1'b0;
    model_char(0, 8'h78);
    idle(3);
    n_cmp++;
    if (b_obs.size() !== b_exp.size()) begin
      n_err++; $display("FAIL b2b_count got=%0d exp=%0d", b_obs.size(), b_exp.size());
    end else begin
      foreach (b_exp[i]) begin
        n_cmp++;
        if (b_obs[i].addr !== b_exp[i].addr || b_obs[i].data !== b_exp[i].data) begin
          n_err++; $display("FAIL b2b_write[%0d] got=(%0d,0x%0h) exp=(%0d,0x%0h)", i, b_obs[i].addr, b_obs[i].data, b_exp[i].addr, b_exp[i].data);
        end
      end
    end
    n_cmp++; if (b_cx !== b_mx || b_cy !== b_my) begin n_err++; $display("FAIL b2b_cursor got=(%0d,%0d) exp=(%0d,%0d)", b_cx, b_cy, b_mx, b_my); end
    clear_q();
  endtask

  task automatic test_random_big();
    int exp_drops;
    bit kb;
    exp_drops = 0; b_drops = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      kb = ($urandom_range(0, 9) < 3);
      b_kb_we = kb; b_kb_addr = 12'($urandom_range(0, 3400)); b_kb_data = 8'($urandom_range(32, 126));
      b_valid = ($urandom_range(0, 3) != 0); b_char = rand_char();
      if (kb) begin
        if (int'(b_kb_addr) < BW * BH) exp_push(0, int'(b_kb_addr), int'(b_kb_data));
        else exp_drops++;
      end else if (b_valid) begin
        model_char(0, int'(b_char));
      end
    end
    @(negedge clk); b_kb_we = 1'b0; b_valid = 1'b0;
    idle(3);
    n_cmp++;
    if (b_obs.size() !== b_exp.size()) begin
      n_err++; $display("FAIL rand_big_count got=%0d exp=%0d", b_obs.size(), b_exp.size());
    end else begin
      foreach (b_exp[i]) begin
        n_cmp++;
        if (b_obs[i].addr !== b_exp[i].addr || b_obs[i].data !== b_exp[i].data) begin
          n_err++; $display("FAIL rand_big_write[%0d] got=(%0d,0x%0h) exp=(%0d,0x%0h)", i, b_obs[i].addr, b_obs[i].data, b_exp[i].addr, b_exp[i].data);
        end
      end
    end
    n_cmp++; if (b_drops !== exp_drops) begin n_err++; $display("FAIL rand_big_drops got=%0d exp=%0d", b_drops, exp_drops); end
    n_cmp++; if (b_cx !== b_mx || b_cy !== b_my) begin n_err++; $display("FAIL rand_big_cursor got=(%0d,%0d) exp=(%0d,%0d)", b_cx, b_cy, b_mx, b_my); end
    clear_q();
  endtask

  task automatic test_clear();
    send(1, 8'h61); send(1, 8'h62);
    idle(2);
    clear_q();
    s_drops = 0; s_busy_cnt = 0;
    @(negedge clk); s_clr = 1'b1; s_kb_we = 1'b1; s_kb_addr = 3'd2; s_kb_data = 8'h6B;
    @(negedge clk); s_clr = 1'b0; s_kb_we = 1'b0;
    #1;
    n_cmp++; if (s_ready !== 1'b0 || s_busy !== 1'b1) begin n_err++; $display("FAIL clear_flags got ready=%0b busy=%0b exp ready=0 busy=1", s_ready, s_busy); end
    @(negedge clk); s_kb_we = 1'b1; s_kb_addr = 3'd1;
    @(negedge clk); s_kb_we = 1'b0;
    @(negedge clk); s_kb_we = 1'b1; s_kb_addr = 3'd5;
    @(negedge clk); s_kb_we = 1'b0;
    idle(10);
    n_cmp++;
    if (s_obs.size() !== SW * SH) begin
      n_err++; $display("FAIL clear_count got=%0d exp=%0d", s_obs.size(), SW * SH);
    end else begin
      foreach (s_obs[i]) begin
        n_cmp++;
        if (s_obs[i].addr !== i || s_obs[i].data !== 32 || s_obs[i].cyc !== s_obs[0].cyc + i) begin
          n_err++; $display("FAIL clear_write[%0d] got=(%0d,0x%0h,+%0d) exp=(%0d,0x20,+%0d)", i, s_obs[i].addr, s_obs[i].data, s_obs[i].cyc - s_obs[0].cyc, i, i);
        end
      end
    end
    n_cmp++; if (s_busy_cnt !== SW * SH) begin n_err++; $display("FAIL clear_busy_cycles got=%0d exp=%0d", s_busy_cnt, SW * SH); end
    n_cmp++; if (s_drops !== 3) begin n_err++; $display("FAIL clear_drops got=%0d exp=3", s_drops); end
    n_cmp++; if (s_cx !== 2'd0 || s_cy !== 1'd0) begin n_err++; $display("FAIL clear_cursor got=(%0d,%0d) exp=(0,0)", s_cx, s_cy); end
    clear_q();
    s_mx = 0; s_my = 0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) send(1, 8'h61);
    idle(2);
    n_cmp++; if (s_cx !== 2'd3 || s_cy !== 1'd1) begin n_err++; $display("FAIL wrap_pre_cursor got=(%0d,%0d) exp=(3,1)", s_cx, s_cy); end
    clear_q();
    s_busy_cnt = 0;
    send(1, 8'h7A);
    idle(12);
    n_cmp++;
    if (s_obs.size() < 1 || s_obs[0].addr !== 7 || s_obs[0].data !== 8'h7A) begin
      n_err++; $display("FAIL wrap_char got_count=%0d exp first=(7,0x7a)", s_obs.size());
    end
    n_cmp++;
    if (s_obs.size() !== s_exp.size()) begin
      n_err++; $display("FAIL wrap_count got=%0d exp=%0d", s_obs.size(), s_exp.size());
    end else begin
      foreach (s_exp[i]) begin
        n_cmp++;
        if (s_obs[i].addr !== s_exp[i].addr || s_obs[i].data !== s_exp[i].data || (i > 1 && s_obs[i].cyc !== s_obs[i-1].cyc + 1)) begin
          n_err++; $display("FAIL wrap_write[%0d] got=(%0d,0x%0h) exp=(%0d,0x%0h)", i, s_obs[i].addr, s_obs[i].data, s_exp[i].addr, s_exp[i].data);
        end
      end
    end
    n_cmp++; if (s_busy_cnt !== (WRAP_EN ? SW * SH : 0)) begin n_err++; $display("FAIL wrap_busy_cycles got=%0d exp=%0d", s_busy_cnt, WRAP_EN ? SW * SH : 0); end
    n_cmp++; if (s_cx !== 2'd0 || s_cy !== 1'd0) begin n_err++; $display("FAIL wrap_cursor got=(%0d,%0d) exp=(0,0)", s_cx, s_cy); end
    clear_q();
  endtask

  task automatic test_random_small();
    for (int n = 0; n < 120; n++) send(1, rand_char());
    idle(12);
    n_cmp++;
    if (s_obs.size() !== s_exp.size()) begin
      n_err++; $display("FAIL rand_small_count got=%0d exp=%0d", s_obs.size(), s_exp.size());
    end else begin
      foreach (s_exp[i]) begin
        n_cmp++;
        if (s_obs[i].addr !== s_exp[i].addr || s_obs[i].data !== s_exp[i].data) begin
          n_err++; $display("FAIL rand_small_write[%0d] got=(%0d,0x%0h) exp=(%0d,0x%0h)", i, s_obs[i].addr, s_obs[i].data, s_exp[i].addr, s_exp[i].data);
        end
      end
    end
    n_cmp++; if (s_cx !== s_mx || s_cy !== s_my) begin n_err++; $display("FAIL rand_small_cursor got=(%0d,%0d) exp=(%0d,%0d)", s_cx, s_cy, s_mx, s_my); end
    clear_q();
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(2);
    test_reset();
    test_keyboard();
    test_stream();
    test_back_to_back();
    test_random_big();
    test_clear();
    test_wrap();
    test_random_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
